// File: rtl/ordenador_16bit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ordenador_16bit
//
// Sequential block sorter. It loads PROF unsigned 16-bit words, bubble-sorts
// them in place with one shared less-or-equal comparator (one compare per
// cycle), then streams them out in ascending order.
//
// Optional feature macro: ORDENADOR_PARADA_ANTECIPADA_EN
//   When defined, a per-pass swap flag ends the sort as soon as a pass makes
//   no swaps. When undefined, the sort always takes PROF*(PROF-1)/2 cycles.
//
// Parameters
//   PROF        words per block (2..16)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   ent_valido  input word valid
//   ent_pronto  sorter accepts an input word (high in load state)
//   ent_dado    input word
//   sai_valido  output word valid (high in output state)
//   sai_pronto  consumer accepts the output word
//   sai_dado    output word mem[k]
//   sai_ultimo  output word is the last of the block
//   ocupado     high while sorting
//   trocas      swaps performed by the most recent sort
// -----------------------------------------------------------------------------

// Unsigned 16-bit less-or-equal comparator shared by every sort step.
module le_16bit (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic        le_o
);
   assign le_o = (a_i <= b_i);
endmodule

module ordenador_16bit #(
   parameter int PROF = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ent_valido,
   output logic        ent_pronto,
   input  logic [15:0] ent_dado,
   output logic        sai_valido,
   input  logic        sai_pronto,
   output logic [15:0] sai_dado,
   output logic        sai_ultimo,
   output logic        ocupado,
   output logic [7:0]  trocas
);

   localparam int              IW     = (PROF > 1) ? $clog2(PROF) : 1;
   localparam logic [IW-1:0]   ULTIMO = IW'(PROF - 1);
   localparam logic [IW-1:0]   PENULT = IW'(PROF - 2);
   localparam logic [IW-1:0]   UM     = IW'(1);

   typedef enum logic [1:0] {
      CARGA  = 2'd0,
      ORDENA = 2'd1,
      SAIDA  = 2'd2
   } estado_t;

   estado_t        state_q, state_d;
   logic [15:0]    mem_q [PROF];
   logic [15:0]    mem_d [PROF];
   logic [IW-1:0]  idx_q, idx_d;
   logic [IW-1:0]  i_q, i_d;
   logic [IW-1:0]  passo_q, passo_d;
   logic [IW-1:0]  k_q, k_d;
   logic [7:0]     trocas_q, trocas_d;
`ifdef ORDENADOR_PARADA_ANTECIPADA_EN
   logic           troca_passo_q, troca_passo_d;  // a swap happened in this pass
`endif

   logic [IW-1:0]  ip1;
   logic           le;
   logic           fim_passo;
   logic           ultimo_passo;

   assign ip1          = i_q + UM;
   assign fim_passo    = (i_q == (PENULT - passo_q));
   assign ultimo_passo = (passo_q == PENULT);

   le_16bit u_le (
      .a_i  (mem_q[i_q]),
      .b_i  (mem_q[ip1]),
      .le_o (le)
   );

   always_comb begin
      // NOTE: every signal written here gets its hold value first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      mem_d    = mem_q;
      idx_d    = idx_q;
      i_d      = i_q;
      passo_d  = passo_q;
      k_d      = k_q;
      trocas_d = trocas_q;
`ifdef ORDENADOR_PARADA_ANTECIPADA_EN
      troca_passo_d = troca_passo_q;
`endif

      // NOTE: blocking assignments in combinational logic, so later lines see
      // the values computed above (e.g. the swap overriding the copied array).
      unique case (state_q)
         CARGA: begin
            if (ent_valido) begin
               mem_d[idx_q] = ent_dado;
               if (idx_q == ULTIMO) begin
                  idx_d    = '0;
                  i_d      = '0;
                  passo_d  = '0;
                  trocas_d = '0;
`ifdef ORDENADOR_PARADA_ANTECIPADA_EN
                  troca_passo_d = 1'b0;
`endif
                  state_d  = ORDENA;
               end else begin
                  idx_d = idx_q + UM;
               end
            end
         end

         ORDENA: begin
            // Swap only on a strict inversion; equal words stay put (stable).
            if (!le) begin
               mem_d[i_q] = mem_q[ip1];
               mem_d[ip1] = mem_q[i_q];
               trocas_d   = trocas_q + 8'd1;
            end
            if (fim_passo) begin
               i_d     = '0;
               passo_d = passo_q + UM;
`ifdef ORDENADOR_PARADA_ANTECIPADA_EN
               troca_passo_d = 1'b0;
               // A pass with no swaps (including this last compare) means
               // the buffer is already in order.
               if (ultimo_passo || (!troca_passo_q && le)) begin
                  state_d = SAIDA;
               end
`else
               if (ultimo_passo) begin
                  state_d = SAIDA;
               end
`endif
            end else begin
               i_d = i_q + UM;
`ifdef ORDENADOR_PARADA_ANTECIPADA_EN
               troca_passo_d = troca_passo_q | !le;
`endif
            end
         end

         SAIDA: begin
            if (sai_pronto) begin
               if (k_q == ULTIMO) begin
                  k_d     = '0;
                  state_d = CARGA;
               end else begin
                  k_d = k_q + UM;
               end
            end
         end

         default: state_d = CARGA;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= CARGA;
         // NOTE: the word array is reset because the block is defined to read
         // back as all zeros after reset (sai_dado = mem[0] = 0).
         mem_q    <= '{default: '0};
         idx_q    <= '0;
         i_q      <= '0;
         passo_q  <= '0;
         k_q      <= '0;
         trocas_q <= '0;
`ifdef ORDENADOR_PARADA_ANTECIPADA_EN
         troca_passo_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         idx_q    <= idx_d;
         i_q      <= i_d;
         passo_q  <= passo_d;
         k_q      <= k_d;
         trocas_q <= trocas_d;
`ifdef ORDENADOR_PARADA_ANTECIPADA_EN
         troca_passo_q <= troca_passo_d;
`endif
      end
   end

   // Handshake flags decode from registers only; no input-to-output path.
   assign ent_pronto = (state_q == CARGA);
   assign ocupado    = (state_q == ORDENA);
   assign sai_valido = (state_q == SAIDA);
   assign sai_ultimo = (state_q == SAIDA) && (k_q == ULTIMO);
   assign sai_dado   = mem_q[k_q];
   assign trocas     = trocas_q;

endmodule

// File: tb/tb_ordenador_16bit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ordenador_16bit
//
// Self-checking bench for ordenador_16bit (PROF=8). Expected output order,
// swap count and sort latency come from a reference model that works on the
// whole block: an insertion sort for the output, the inversion count for the
// swaps, and the largest "greater words to the left" count for the number of
// passes needed when early stop is enabled.
// -----------------------------------------------------------------------------
module tb_ordenador_16bit;

   localparam int PROF = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ent_valido = 1'b0;
   logic        ent_pronto;
   logic [15:0] ent_dado = '0;
   logic        sai_valido;
   logic        sai_pronto = 1'b0;
   logic [15:0] sai_dado;
   logic        sai_ultimo;
   logic        ocupado;
   logic [7:0]  trocas;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] blk     [PROF];
   logic [15:0] exp_out [PROF];
   int          exp_trocas;
   int          exp_lat;

   ordenador_16bit #(.PROF(PROF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ent_valido (ent_valido),
      .ent_pronto (ent_pronto),
      .ent_dado   (ent_dado),
      .sai_valido (sai_valido),
      .sai_pronto (sai_pronto),
      .sai_dado   (sai_dado),
      .sai_ultimo (sai_ultimo),
      .ocupado    (ocupado),
      .trocas     (trocas)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference model for the block currently held in blk.
   task automatic build_model();
      int          g;
      int          p;
      int          b;
      int          passes;
      logic [15:0] v;
      p = 0;
      exp_trocas = 0;
      for (int j = 0; j < PROF; j++) begin
         g = 0;
         for (int i = 0; i < j; i++) if (blk[i] > blk[j]) g++;
         exp_trocas += g;
         if (g > p) p = g;
      end
      exp_out = blk;
      for (int a = 1; a < PROF; a++) begin
         v = exp_out[a];
         b = a - 1;
         while (b >= 0 && exp_out[b] > v) begin
            exp_out[b+1] = exp_out[b];
            b--;
         end
         exp_out[b+1] = v;
      end
`ifdef ORDENADOR_PARADA_ANTECIPADA_EN
      passes = (p + 1 < PROF - 1) ? p + 1 : PROF - 1;
`else
      passes = PROF - 1;
`endif
      exp_lat = 0;
      for (int j = 0; j < passes; j++) exp_lat += PROF - 1 - j;
   endtask

   // Loads blk, measures the sort, drains the output and checks everything.
   // gap_mode: 1 inserts random bubbles in ent_valido.
   // ready_mode: 0 always ready, 1 alternate cycles, 2 random.
   // hold_valid: keep ent_valido high with junk data during the sort.
   task automatic run_block(input string nome, input int gap_mode,
                            input int ready_mode, input bit hold_valid);
      int          n;
      int          cyc;
      int          k;
      bit          stalled;
      logic [15:0] prev;
      build_model();

      n = 0;
      while (n < PROF) begin
         @(negedge clk);
         n_checks++;
         if (ent_pronto !== 1'b1) begin
            n_fail++;
            $display("FAIL %s load_ent_pronto: got %b expected 1", nome, ent_pronto);
         end
         if (gap_mode != 0 && $urandom_range(0, 2) == 0) begin
            ent_valido = 1'b0;
            ent_dado   = 16'($urandom);
         end else begin
            ent_valido = 1'b1;
            ent_dado   = blk[n];
            n++;
         end
      end

      @(negedge clk);
      if (hold_valid) begin
         ent_valido = 1'b1;
         ent_dado   = 16'($urandom);
      end else begin
         ent_valido = 1'b0;
      end

      cyc = 0;
      while (ocupado === 1'b1 && cyc < 200) begin
         n_checks++;
         if (ent_pronto !== 1'b0 || sai_valido !== 1'b0) begin
            n_fail++;
            $display("FAIL %s sort_flags: ent_pronto=%b sai_valido=%b expected 0 0",
                     nome, ent_pronto, sai_valido);
         end
         if (hold_valid) ent_dado = 16'($urandom);
         cyc++;
         @(negedge clk);
      end
      ent_valido = 1'b0;

      n_checks++;
      if (cyc != exp_lat) begin
         n_fail++;
         $display("FAIL %s sort_latency: got %0d cycles expected %0d", nome, cyc, exp_lat);
      end
      n_checks++;
      if (trocas !== 8'(exp_trocas)) begin
         n_fail++;
         $display("FAIL %s trocas: got %0d expected %0d", nome, trocas, exp_trocas);
      end

      k = 0;
      cyc = 0;
      stalled = 1'b0;
      prev = '0;
      while (k < PROF && cyc < 200) begin
         n_checks++;
         if (sai_valido !== 1'b1) begin
            n_fail++;
            $display("FAIL %s sai_valido[%0d]: got %b expected 1", nome, k, sai_valido);
         end
         n_checks++;
         if (sai_dado !== exp_out[k]) begin
            n_fail++;
            $display("FAIL %s sai_dado[%0d]: got %h expected %h", nome, k, sai_dado, exp_out[k]);
         end
         n_checks++;
         if (sai_ultimo !== (k == PROF - 1)) begin
            n_fail++;
            $display("FAIL %s sai_ultimo[%0d]: got %b expected %b", nome, k, sai_ultimo, k == PROF - 1);
         end
         if (stalled) begin
            n_checks++;
            if (sai_dado !== prev) begin
               n_fail++;
               $display("FAIL %s stall_hold[%0d]: got %h expected %h", nome, k, sai_dado, prev);
            end
         end
         prev = sai_dado;
         case (ready_mode)
            0:       sai_pronto = 1'b1;
            1:       sai_pronto = (cyc % 2 == 1);
            default: sai_pronto = ($urandom_range(0, 1) == 1);
         endcase
         stalled = !sai_pronto;
         if (sai_pronto) k++;
         cyc++;
         @(negedge clk);
      end
      sai_pronto = 1'b0;

      n_checks++;
      if (k != PROF) begin
         n_fail++;
         $display("FAIL %s drain_timeout: got %0d words expected %0d", nome, k, PROF);
      end
      n_checks++;
      if (ent_pronto !== 1'b1 || sai_valido !== 1'b0 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL %s return_carga: ent_pronto=%b sai_valido=%b ocupado=%b expected 1 0 0",
                  nome, ent_pronto, sai_valido, ocupado);
      end
      n_checks++;
      if (trocas !== 8'(exp_trocas)) begin
         n_fail++;
         $display("FAIL %s trocas_hold: got %0d expected %0d", nome, trocas, exp_trocas);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (ent_pronto !== 1'b1 || sai_valido !== 1'b0 || sai_ultimo !== 1'b0 ||
          ocupado !== 1'b0 || sai_dado !== 16'h0000 || trocas !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: pronto=%b valido=%b ultimo=%b ocupado=%b dado=%h trocas=%h expected 1 0 0 0 0000 00",
                  ent_pronto, sai_valido, sai_ultimo, ocupado, sai_dado, trocas);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ent_pronto !== 1'b1 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ent_pronto=%b ocupado=%b expected 1 0", ent_pronto, ocupado);
      end
   endtask

   task automatic test_reverse();
      blk = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
      run_block("reverse", 0, 0, 1'b0);
   endtask

   task automatic test_sorted();
      blk = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      run_block("sorted", 0, 0, 1'b0);
   endtask

   task automatic test_extremes();
      blk = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h8000};
      run_block("extremes", 0, 0, 1'b0);
   endtask

   task automatic test_flow_control();
      for (int i = 0; i < PROF; i++) blk[i] = 16'($urandom);
      run_block("flow_alt", 1, 1, 1'b0);
      for (int i = 0; i < PROF; i++) blk[i] = 16'($urandom);
      run_block("ignore_in_sort", 0, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < PROF; i++)
            blk[i] = (b % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         run_block("random", b % 2, 2, 1'b0);
      end
   endtask

   task automatic test_reset_mid_sort();
      for (int i = 0; i < PROF; i++) blk[i] = 16'(PROF - i) + 16'h0100;
      for (int i = 0; i < PROF; i++) begin
         @(negedge clk);
         ent_valido = 1'b1;
         ent_dado   = blk[i];
      end
      @(negedge clk);
      ent_valido = 1'b0;
      repeat (9) @(negedge clk);
      n_checks++;
      if (ocupado !== 1'b1) begin
         n_fail++;
         $display("FAIL midsort_busy: ocupado=%b expected 1", ocupado);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ent_pronto !== 1'b1 || sai_valido !== 1'b0 || sai_ultimo !== 1'b0 ||
          ocupado !== 1'b0 || sai_dado !== 16'h0000 || trocas !== 8'h00) begin
         n_fail++;
         $display("FAIL midsort_reset_outputs: pronto=%b valido=%b ultimo=%b ocupado=%b dado=%h trocas=%h expected 1 0 0 0 0000 00",
                  ent_pronto, sai_valido, sai_ultimo, ocupado, sai_dado, trocas);
      end
      for (int i = 0; i < PROF; i++) begin
         n_checks++;
         if (dut.mem_q[i] !== 16'h0000) begin
            n_fail++;
            $display("FAIL midsort_reset_mem[%0d]: got %h expected 0000", i, dut.mem_q[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ent_pronto !== 1'b1 || ocupado !== 1'b0) begin
         n_fail++;
         $display("FAIL midsort_release: ent_pronto=%b ocupado=%b expected 1 0", ent_pronto, ocupado);
      end
      blk = '{16'd3, 16'd1, 16'd2, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      run_block("after_reset", 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_reverse();
      test_sorted();
      test_extremes();
      test_flow_control();
      test_back_to_back();
      test_reset_mid_sort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ordenador_16bit.md
# ordenador_16bit

Sequential sorter built around a single shared 16-bit unsigned less-or-equal comparator (LE_16bit). It accepts a block of PROF words over a valid/ready input, sorts them in ascending unsigned order using bubble sort with one compare per cycle, then streams them out over a valid/ready output. It sits beside the ALU datapath as the control and scheduling layer that sequences the comparator across the whole buffer.

## Interface

**Parameters**
- `PROF`, default 8: number of words per block. Legal range is 2..16.

**Ports**
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ent_valido`, input, 1: input word valid.
- `ent_pronto`, output, 1: sorter accepts an input word.
- `ent_dado`, input, 16: input word.
- `sai_valido`, output, 1: output word valid.
- `sai_pronto`, input, 1: consumer accepts the output word.
- `sai_dado`, output, 16: output word.
- `sai_ultimo`, output, 1: marks the last word (index PROF-1) of the block.
- `ocupado`, output, 1: high while sorting.
- `trocas`, output, 8: number of swaps performed in the most recent sort.

## Operation

- **Storage:** register array `mem[0..PROF-1]` of 16-bit words.
- **FSM states:** CARGA, ORDENA, SAIDA. Reset enters CARGA.
- **CARGA**
  - `ent_pronto`=1.
  - On `ent_valido && ent_pronto`, write `ent_dado` to `mem[idx]` and increment `idx`.
  - On accepting word PROF-1: next state is ORDENA. `idx`, `passo` and `trocas` are cleared.
- **ORDENA**
  - `ocupado`=1, `ent_pronto`=0.
  - Each cycle, the comparator evaluates `mem[i] <= mem[i+1]`.
  - If the result is 0, swap the two words in the same cycle and increment `trocas`.
  - Equal words are never swapped, so the sort is stable.
  - `i` runs from 0 to PROF-2-`passo`. At the end of each pass, `passo` increments and `i` returns to 0.
  - After the pass with `passo`=PROF-2 completes, next state is SAIDA.
- **SAIDA**
  - `sai_valido`=1, `sai_dado`=`mem[k]`, `sai_ultimo`=(`k`==PROF-1).
  - On `sai_valido && sai_pronto`, `k` increments.
  - On the handshake with `sai_ultimo`=1: next state is CARGA and `k` is cleared.
- **Comparison:** unsigned, full 16 bits, so 0xFFFF is the largest value.
- **`trocas`:** holds its value from the end of ORDENA until the next entry to ORDENA. Its maximum is 120 (PROF=16), so it does not saturate.
- **Input while not in CARGA:** `ent_valido` outside CARGA is ignored and no data is lost, because `ent_pronto`=0.
- **Reset at any time, including mid-ORDENA or mid-SAIDA:** aborts the block and returns to CARGA.

## Timing

- **Reset values:** `ent_pronto`=1, `sai_valido`=0, `sai_dado`=0, `sai_ultimo`=0, `ocupado`=0, `trocas`=0. All `mem` words, `idx`, `i`, `passo` and `k` are 0.
- **Output decoding:** `ent_pronto`, `sai_valido`, `sai_ultimo` and `ocupado` decode from the state register only. There is no combinational path from `ent_valido` or `sai_pronto` to any output.
- **Load:** a minimum of PROF cycles, one word per cycle with no bubbles required.
- **ORDENA entry:** the first cycle after the last CARGA handshake.
- **Sort latency (macro absent):** exactly PROF·(PROF-1)/2 cycles in ORDENA, regardless of data. For PROF=8 this is 28 cycles.
- **First output:** `sai_valido` rises in the cycle after the last ORDENA cycle.
- **Output rate:** one word per cycle while `sai_pronto`=1.
- **Backpressure:** `sai_dado` and `sai_ultimo` hold while `sai_valido && !sai_pronto`.
- **Return to CARGA:** the cycle after the last output handshake. `ent_pronto`=1 in that cycle.

## Configuration

- **`ORDENADOR_PARADA_ANTECIPADA_EN` defined:** a per-pass swap flag is kept.
  - If a pass completes with no swaps, next state is SAIDA immediately.
  - For already-sorted input, latency is PROF-1 cycles (7 for PROF=8).
  - Worst case is unchanged at PROF·(PROF-1)/2 cycles.
- **Macro undefined:** no flag exists and the fixed latency of PROF·(PROF-1)/2 cycles applies. Output data is identical in both builds.

## Test plan

All scenarios use PROF=8.

- **Reverse input:** load 8,7,6,5,4,3,2,1 -> output 1..8, `trocas`=28, `ocupado` high for 28 cycles, `sai_ultimo` only on 8.
- **Sorted input:** load 1..8 -> output 1..8, `trocas`=0. `ocupado` lasts 28 cycles without the macro and 7 cycles with it.
- **Extremes and duplicates:** load 0xFFFF,0x0000,0x8000,0x7FFF,0x0000,0x0001,0xFFFF,0x8000 -> output 0x0000,0x0000,0x0001,0x7FFF,0x8000,0x8000,0xFFFF,0xFFFF.
- **Flow control:**
  - Load with gaps in `ent_valido`, then apply `sai_pronto` high on alternate cycles -> every word is emitted exactly once in order, and `sai_dado` is stable while stalled.
  - `ent_valido`=1 held during ORDENA -> ignored; `ent_pronto`=0.
- **Reset mid-sort:** assert `rst_n`=0 at cycle 10 of ORDENA -> all outputs and `mem` at reset values, `ent_pronto`=1 after release. A fresh load of 3,1,2,…,8 then sorts correctly.
